// File: rtl/snoop_ac_if.sv
// ACE AC-channel handshake bundle: valid/ready plus address, snoop type and protection.
// The master modport drives valid and the payload; the slave modport drives ready.
interface snoop_ac_if #(
  parameter int AddrWidth = 64
);
  logic                 valid;
  logic                 ready;
  logic [AddrWidth-1:0] addr;
  logic [3:0]           snoop;
  logic [2:0]           prot;

  modport master (output valid, output addr, output snoop, output prot, input ready);
  modport slave  (input valid, input addr, input snoop, input prot, output ready);
endinterface

// File: rtl/snoop_ac_queue.sv
// AC snoop FIFO that holds the head back on MSHR line collisions or a cache flush.
// Define SNOOP_AC_QUEUE_STATS_EN to add saturating accept/stall counters.
module snoop_ac_queue #(
  parameter int Depth      = 4,
  parameter int AddrWidth  = 64,
  parameter int LineOffset = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  snoop_ac_if.slave              up,
  snoop_ac_if.master             dn,
  input  logic                   mshr_valid_i,
  input  logic [AddrWidth-1:0]   mshr_addr_i,
  input  logic                   flushing_i,
  output logic [$clog2(Depth):0] count_o
`ifdef SNOOP_AC_QUEUE_STATS_EN
  ,
  output logic [31:0]            stat_accept_o,
  output logic [31:0]            stat_stall_o
`endif
);
  localparam int PW = $clog2(Depth);
  localparam logic [PW:0] FULL = (PW+1)'(Depth);

  typedef struct packed {
    logic [AddrWidth-1:0] addr;
    logic [3:0]           snoop;
    logic [2:0]           prot;
  } entry_t;

  entry_t        mem_q [Depth];
  logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [PW:0]   cnt_q, cnt_d;
  logic          pres_q, pres_d;
  logic          push, pop, hazard;
  entry_t        head;

  assign head   = mem_q[rd_q];
  assign hazard = mshr_valid_i &
                  (head.addr[AddrWidth-1:LineOffset] == mshr_addr_i[AddrWidth-1:LineOffset]);

  // Once presented the head stays valid; hazard/flush only gate a fresh presentation.
  assign up.ready = (cnt_q != FULL);
  assign dn.valid = (cnt_q != '0) & (pres_q | (~hazard & ~flushing_i));
  assign dn.addr  = head.addr;
  assign dn.snoop = head.snoop;
  assign dn.prot  = head.prot;
  assign count_o  = cnt_q;

  assign push = up.valid & up.ready;
  assign pop  = dn.valid & dn.ready;

  always_comb begin
    rd_d   = rd_q;
    wr_d   = wr_q;
    cnt_d  = cnt_q;
    pres_d = pres_q;
    if (push) wr_d = wr_q + 1'b1;
    if (pop)  rd_d = rd_q + 1'b1;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    if (pop)                        pres_d = 1'b0;
    else if (dn.valid && !dn.ready) pres_d = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_q   <= '0;
      wr_q   <= '0;
      cnt_q  <= '0;
      pres_q <= 1'b0;
      for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
    end else begin
      rd_q   <= rd_d;
      wr_q   <= wr_d;
      cnt_q  <= cnt_d;
      pres_q <= pres_d;
      if (push) mem_q[wr_q] <= '{addr: up.addr, snoop: up.snoop, prot: up.prot};
    end
  end

`ifdef SNOOP_AC_QUEUE_STATS_EN
  logic [31:0] acc_q, stall_q;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q   <= '0;
      stall_q <= '0;
    end else begin
      if (push && acc_q != '1) acc_q <= acc_q + 1'b1;
      if ((cnt_q != '0) && !dn.valid && stall_q != '1) stall_q <= stall_q + 1'b1;
    end
  end
  assign stat_accept_o = acc_q;
  assign stat_stall_o  = stall_q;
`endif
endmodule
